// File: rtl/pkt_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : pkt_rr_arbiter
// Purpose : Round-robin packet arbiter with bounded bursts and a registered,
//           ready-handshaked output slot.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pkt_rr_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int PW        = 49,
    parameter int MAX_BURST = 4,
    localparam int IW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_IN*PW-1:0] in_pkt,
    output logic [NUM_IN-1:0]    in_ack,
    output logic [PW-1:0]        out_pkt,
    input  logic                 out_ready,
    output logic [IW-1:0]        grant_id,
    output logic                 busy
);

    localparam int CW = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_burst_cnt;
    logic [PW-1:0]   r_out_pkt;

    logic [PW-1:0]   w_slice [NUM_IN];
    logic [NUM_IN-1:0] w_valid;
    logic [IW-1:0]   w_first;
    logic [IW:0]     w_idx;
    logic [IW-1:0]   w_next_ptr;
    logic            w_slot_free;
    logic            w_ack;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign w_slice[gi] = in_pkt[gi*PW +: PW];
            assign w_valid[gi] = in_pkt[gi*PW + PW - 1];
        end
    endgenerate

    // Scan offsets from high to low so the smallest offset from r_rr_ptr wins.
    always_comb begin
        w_first = '0;
        w_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NUM_IN)) begin
                w_idx = w_idx - (IW+1)'(NUM_IN);
            end
            if (w_valid[w_idx[IW-1:0]]) begin
                w_first = w_idx[IW-1:0];
            end
        end
    end

    assign w_slot_free = ~r_out_pkt[PW-1] | out_ready;
    assign w_ack       = (r_state == ST_GRANT) & w_valid[r_owner] & w_slot_free;
    assign w_next_ptr  = (r_owner == IW'(NUM_IN - 1)) ? '0 : r_owner + IW'(1);

    always_comb begin
        in_ack = '0;
        if (w_ack) begin
            in_ack[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_out_pkt   <= '0;
        end else begin
            // A consumed slot empties unless a new packet is loaded below.
            if (r_out_pkt[PW-1] && out_ready) begin
                r_out_pkt[PW-1] <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (|w_valid) begin
                        r_owner     <= w_first;
                        r_burst_cnt <= '0;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_ack) begin
                        r_out_pkt   <= w_slice[r_owner];
                        r_burst_cnt <= r_burst_cnt + CW'(1);
                        if (r_burst_cnt == CW'(MAX_BURST - 1)) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else if (w_slot_free) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_pkt  = r_out_pkt;
    assign grant_id = r_owner;
    assign busy     = (r_state == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_pkt_rr_arbiter
// Purpose : Randomized self-checking bench for pkt_rr_arbiter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pkt_rr_arbiter;

    localparam int NUM_IN    = 4;
    localparam int PW        = 49;
    localparam int MAX_BURST = 4;
    localparam int IW        = 2;
    localparam int DW        = PW - 1;
    localparam int VW        = NUM_IN + 1 + IW + 1 + DW;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_IN*PW-1:0] in_pkt;
    logic [NUM_IN-1:0]    in_ack;
    logic [PW-1:0]        out_pkt;
    logic                 out_ready = 1'b0;
    logic [IW-1:0]        grant_id;
    logic                 busy;

    // Source i offers src_d[i] while rem[i] != 0; rem < 0 means endless.
    int                   rem [NUM_IN];
    logic [DW-1:0]        src_d [NUM_IN];

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level reference state.
    bit            m_grant, m_ov;
    int            m_owner, m_ptr, m_cnt;
    logic [DW-1:0] m_od;

    logic [NUM_IN-1:0] s_ack;
    logic [DW-1:0]     tx_q [$];
    logic [DW-1:0]     rx_q [$];

    pkt_rr_arbiter #(.NUM_IN(NUM_IN), .PW(PW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_pkt    (in_pkt),
        .in_ack    (in_ack),
        .out_pkt   (out_pkt),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_pkt[i*PW +: PW] = {rem[i] != 0, src_d[i]};
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_IN-1:0] a;
        a = '0;
        if (m_grant && rem[m_owner] != 0 && (!m_ov || out_ready)) a[m_owner] = 1'b1;
        return {a, m_grant, m_grant ? IW'(m_owner) : IW'(0), m_ov, m_ov ? m_od : DW'(0)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {in_ack, busy, busy ? grant_id : IW'(0), out_pkt[PW-1],
                out_pkt[PW-1] ? out_pkt[DW-1:0] : DW'(0)};
    endfunction

    task automatic model_reset();
        m_grant = 1'b0; m_ov = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_od = '0;
        s_ack = '0;
    endtask

    task automatic sample();
        s_ack = in_ack;
        for (int i = 0; i < NUM_IN; i++) if (in_ack[i] === 1'b1) tx_q.push_back(src_d[i]);
        if (out_pkt[PW-1] === 1'b1 && out_ready) rx_q.push_back(out_pkt[DW-1:0]);
    endtask

    // Apply one clock edge to the reference, then let sources react to acks.
    task automatic advance();
        bit sf, ack, found;
        @(posedge clk);
        sf  = !m_ov || out_ready;
        ack = m_grant && rem[m_owner] != 0 && sf;
        if (m_ov && out_ready) m_ov = 1'b0;
        if (!m_grant) begin
            found = 1'b0;
            for (int k = 0; k < NUM_IN; k++) begin
                if (!found && rem[(m_ptr + k) % NUM_IN] != 0) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % NUM_IN;
                end
            end
            if (found) begin
                m_grant = 1'b1;
                m_cnt   = 0;
            end
        end else if (ack) begin
            m_ov = 1'b1;
            m_od = src_d[m_owner];
            m_cnt++;
            if (m_cnt == MAX_BURST) begin
                m_grant = 1'b0;
                m_ptr   = (m_owner + 1) % NUM_IN;
            end
        end else if (sf) begin
            m_grant = 1'b0;
            m_ptr   = (m_owner + 1) % NUM_IN;
        end
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (s_ack[i] === 1'b1) begin
                src_d[i] = rnd_data();
                if (rem[i] > 0) rem[i]--;
            end
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) rem[i] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            rem[i]   = 0;
            src_d[i] = rnd_data();
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (obs_vec() !== exp_vec() || out_pkt !== '0) begin
            n_err++;
            $display("FAIL reset_state: got ack=%b busy=%b out=%h, want all zero", in_ack, busy, out_pkt);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        apply_reset();
        src_d[2] = 48'h0000_0000_00A5;
        rem[2]   = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sample();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 1) begin
                n_vec++;
                if (in_ack !== 4'b0100) begin
                    n_err++;
                    $display("FAIL single_ack: got %b want 0100", in_ack);
                end
            end
            if (k == 2) begin
                n_vec++;
                if (out_pkt[PW-1] !== 1'b1 || out_pkt[31:0] !== 32'h0000_00A5) begin
                    n_err++;
                    $display("FAIL single_out: got v=%b pay=%h want v=1 pay=000000a5", out_pkt[PW-1], out_pkt[31:0]);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_busy: got %b want 0", busy);
                end
            end
            advance();
        end
    endtask

    task automatic test_burst();
        logic [NUM_IN-1:0] e;
        apply_reset();
        rem[0] = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            sample();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL burst_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            e = (k % 5 != 0) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (in_ack !== e) begin
                n_err++;
                $display("FAIL burst_pattern_c%0d: got %b want %b", k, in_ack, e);
            end
            advance();
        end
    endtask

    task automatic test_rr();
        int order [3];
        int acks2;
        logic [NUM_IN-1:0] e;
        order[0] = 0; order[1] = 1; order[2] = 3;
        acks2 = 0;
        apply_reset();
        rem[0] = -1; rem[1] = -1; rem[3] = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            sample();
            if (in_ack[2] === 1'b1) acks2++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rr_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            e = (k % 5 != 0) ? NUM_IN'(1 << order[(k / 5) % 3]) : '0;
            n_vec++;
            if (in_ack !== e) begin
                n_err++;
                $display("FAIL rr_order_c%0d: got %b want %b", k, in_ack, e);
            end
            advance();
        end
        n_vec++;
        if (acks2 != 0) begin
            n_err++;
            $display("FAIL rr_in2_acked: got %0d acks want 0", acks2);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] held;
        held = '0;
        apply_reset();
        tx_q.delete();
        rx_q.delete();
        rem[1] = -1;
        for (int k = 0; k < 75; k++) begin
            if (k >= 2 && k <= 6)       out_ready = 1'b0;
            else if (k >= 8 && k < 55)  out_ready = ($urandom_range(0, 9) < 7);
            else                        out_ready = 1'b1;
            if (k >= 8 && k < 55) begin
                for (int i = 0; i < NUM_IN; i++)
                    if ($urandom_range(0, 5) == 0) rem[i] = int'($urandom_range(0, 4)) - 1;
            end else if (k >= 55) begin
                for (int i = 0; i < NUM_IN; i++) rem[i] = 0;
            end
            @(negedge clk);
            sample();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL bp_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 2) held = out_pkt;
            if (k >= 2 && k <= 6) begin
                n_vec++;
                if (in_ack !== '0 || busy !== 1'b1 || out_pkt[PW-1] !== 1'b1 || (k > 2 && out_pkt !== held)) begin
                    n_err++;
                    $display("FAIL bp_stall_c%0d: got ack=%b busy=%b out=%h want ack=0 busy=1 out=%h",
                             k, in_ack, busy, out_pkt, held);
                end
            end
            if (k == 7) begin
                n_vec++;
                if (in_ack !== 4'b0010 || out_pkt !== held) begin
                    n_err++;
                    $display("FAIL bp_resume: got ack=%b out=%h want ack=0010 out=%h", in_ack, out_pkt, held);
                end
            end
            advance();
        end
        n_vec++;
        if (tx_q.size() != rx_q.size() || tx_q.size() < 5) begin
            n_err++;
            $display("FAIL bp_count: got %0d received want %0d sent", rx_q.size(), tx_q.size());
        end else begin
            for (int i = 0; i < tx_q.size(); i++) begin
                n_vec++;
                if (rx_q[i] !== tx_q[i]) begin
                    n_err++;
                    $display("FAIL bp_seq%0d: got %h want %h", i, rx_q[i], tx_q[i]);
                end
            end
        end
    endtask

    task automatic test_early();
        int seq [$];
        apply_reset();
        rem[1] = 2;
        rem[3] = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sample();
            for (int i = 0; i < NUM_IN; i++) if (in_ack[i] === 1'b1) seq.push_back(i);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL early_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 5) begin
                n_vec++;
                if (busy !== 1'b1 || grant_id !== 2'd3) begin
                    n_err++;
                    $display("FAIL early_regrant: got busy=%b id=%0d want busy=1 id=3", busy, grant_id);
                end
            end
            advance();
        end
        n_vec++;
        if (seq.size() != 3 || seq[0] != 1 || seq[1] != 1 || seq[2] != 3) begin
            n_err++;
            $display("FAIL early_order: got %0d acks %p want 1,1,3", seq.size(), seq);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 1; i < NUM_IN; i++) rem[i] = -1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sample();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_pre_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            advance();
        end
        rem[0] = -1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (out_pkt !== '0 || in_ack !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL arst_clear: got out=%h ack=%b busy=%b want all zero", out_pkt, in_ack, busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sample();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_post_c%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 1) begin
                n_vec++;
                if (in_ack !== 4'b0001 || grant_id !== 2'd0) begin
                    n_err++;
                    $display("FAIL arst_first_grant: got ack=%b id=%0d want ack=0001 id=0", in_ack, grant_id);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_rr();
        test_backpressure();
        test_early();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
